// File: rtl/pa_spsram_ctrl.sv
// Purpose     : single-port SRAM front end: request handshake, byte strobe to bit-WEN, init sweep after reset or on demand.
// Latency     : macro access in the accept cycle; rd_vld/rd_data one cycle after a read is accepted.
// Backpressure: req_rdy low for the whole sweep (2^ADDR_WIDTH cycles); otherwise one request accepted per cycle.
module pa_spsram_ctrl #(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 32,
   parameter bit                    INIT_EN    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
   input  logic                    forever_cpuclk,
   input  logic                    cpurst_b,
   input  logic                    req_vld,
   output logic                    req_rdy,
   input  logic                    req_wr,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_bwe,
   input  logic                    init_req,
   output logic                    init_done,
   output logic                    rd_vld,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic [ADDR_WIDTH-1:0]   ram_a,
   output logic                    ram_cen,
   output logic                    ram_gwen,
   output logic [DATA_WIDTH-1:0]   ram_wen,
   output logic [DATA_WIDTH-1:0]   ram_d,
   input  logic [DATA_WIDTH-1:0]   ram_q
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_INIT = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_WIDTH-1:0]   init_cnt;
   logic [ADDR_WIDTH-1:0]   init_cnt_nxt;
   logic [DATA_WIDTH-1:0]   rd_hold;
   logic                    req_acc;
   logic                    rd_acc;
   logic                    wr_acc;
   logic                    init_act;

   assign req_rdy   = (state == ST_IDLE);
   assign init_done = (state == ST_IDLE);

   // Reset is folded in so the macro pins sit at their idle levels while reset is held,
   // even though the state register already points at INIT.
   assign req_acc  = req_vld & req_rdy & cpurst_b;
   assign rd_acc   = req_acc & ~req_wr;
   // A write with no strobes is consumed but never touches the macro.
   assign wr_acc   = req_acc & req_wr & (|req_bwe);
   assign init_act = (state == ST_INIT) & cpurst_b;

   // The pulse cycle forwards ram_q directly; the hold register covers every other cycle.
   assign rd_data = rd_vld ? ram_q : rd_hold;

   // State, sweep counter, read pulse and read-data hold register.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state    <= INIT_EN ? ST_INIT : ST_IDLE;
         init_cnt <= '0;
         rd_vld   <= 1'b0;
         rd_hold  <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
         rd_vld   <= rd_acc;
         if (rd_vld) begin
            rd_hold <= ram_q;
         end
      end
   end

   // Next state: sweep walks every word once, IDLE leaves only on init_req.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      case (state)
         ST_INIT: begin
            if (&init_cnt) begin
               state_nxt    = ST_IDLE;
               init_cnt_nxt = '0;
            end else begin
               init_cnt_nxt = init_cnt + CNT_ONE;
            end
         end
         ST_IDLE: begin
            if (init_req) begin
               state_nxt = ST_INIT;
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            init_cnt_nxt = '0;
         end
      endcase
   end

   // Macro pins: sweep write, request read or request write; idle otherwise.
   always_comb begin
      ram_cen  = 1'b1;
      ram_gwen = 1'b1;
      ram_wen  = '1;
      ram_a    = '0;
      ram_d    = '0;
      if (init_act) begin
         ram_cen  = 1'b0;
         ram_gwen = 1'b0;
         ram_wen  = '0;
         ram_a    = init_cnt;
         ram_d    = INIT_VAL;
      end else if (rd_acc) begin
         ram_cen  = 1'b0;
         ram_a    = req_addr;
      end else if (wr_acc) begin
         ram_cen  = 1'b0;
         ram_gwen = 1'b0;
         ram_a    = req_addr;
         ram_d    = req_wdata;
         for (int i = 0; i < BYTES; i++) begin
            ram_wen[8*i +: 8] = {8{~req_bwe[i]}};
         end
      end
   end

endmodule

// File: tb/tb_pa_spsram_ctrl.sv
module tb_pa_spsram_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic          clk;
   logic          cpurst_b;
   logic          req_vld;
   logic          req_rdy;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [3:0]    req_bwe;
   logic          init_req;
   logic          init_done;
   logic          rd_vld;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] ram_a;
   logic          ram_cen;
   logic          ram_gwen;
   logic [DW-1:0] ram_wen;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] ram_q;

   int            n_chk;
   int            n_pass;

   // word-level reference memory and last value the requester saw
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] last_rd;

   // behavioural single-port macro with active-low enables, one-cycle read latency
   logic [DW-1:0] sram [DEPTH];

   pa_spsram_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .INIT_EN    (1'b1),
      .INIT_VAL   (32'h0)
   ) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (cpurst_b),
      .req_vld        (req_vld),
      .req_rdy        (req_rdy),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_bwe        (req_bwe),
      .init_req       (init_req),
      .init_done      (init_done),
      .rd_vld         (rd_vld),
      .rd_data        (rd_data),
      .ram_a          (ram_a),
      .ram_cen        (ram_cen),
      .ram_gwen       (ram_gwen),
      .ram_wen        (ram_wen),
      .ram_d          (ram_d),
      .ram_q          (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ram_cen) begin
         if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
         else           ram_q <= sram[ram_a];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_bwe = '0; init_req = 1'b0;
      #1;
   endtask

   task automatic drive_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [3:0] bwe);
      req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_bwe = bwe;
      #1;
   endtask

   // byte-granular write semantics as the requester sees them
   function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                       input logic [3:0] bwe);
      for (int b = 0; b < 4; b++)
         if (bwe[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
   endfunction

   function automatic void model_sweep();
      for (int w = 0; w < DEPTH; w++) ref_mem[w] = 32'h0;
   endfunction

   task automatic test_reset();
      cpurst_b = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (req_rdy !== 1'b0 || init_done !== 1'b0 || rd_vld !== 1'b0 || rd_data !== 32'h0 ||
          ram_cen !== 1'b1 || ram_gwen !== 1'b1 || ram_wen !== 32'hFFFF_FFFF)
         $display("FAIL reset_vals: rdy=%b done=%b rd_vld=%b rd_data=%h cen=%b gwen=%b wen=%h, required 0 0 0 0 1 1 ffffffff",
                  req_rdy, init_done, rd_vld, rd_data, ram_cen, ram_gwen, ram_wen);
      else n_pass++;
      cpurst_b = 1'b1;
      #1;
      for (int k = 0; k < DEPTH; k++) begin
         n_chk++;
         if (ram_cen !== 1'b0 || ram_gwen !== 1'b0 || ram_wen !== 32'h0 || ram_a !== k[AW-1:0] ||
             ram_d !== 32'h0 || req_rdy !== 1'b0 || init_done !== 1'b0)
            $display("FAIL sweep_cycle%0d: cen=%b gwen=%b wen=%h a=%0d d=%h rdy=%b, required 0 0 0 %0d 0 0",
                     k, ram_cen, ram_gwen, ram_wen, ram_a, ram_d, req_rdy, k);
         else n_pass++;
         step();
      end
      n_chk++;
      if (req_rdy !== 1'b1 || init_done !== 1'b1 || ram_cen !== 1'b1)
         $display("FAIL sweep_end: rdy=%b done=%b cen=%b, required 1 1 1", req_rdy, init_done, ram_cen);
      else n_pass++;
      model_sweep();
      last_rd = 32'h0;
   endtask

   task automatic test_byte_strobe();
      drive_req(1'b1, 4'd5, 32'h1234_5678, 4'b1111);
      n_chk++;
      if (ram_cen !== 1'b0 || ram_gwen !== 1'b0 || ram_wen !== 32'h0 || ram_a !== 4'd5 || ram_d !== 32'h1234_5678)
         $display("FAIL full_write: cen=%b gwen=%b wen=%h a=%0d d=%h, required 0 0 00000000 5 12345678",
                  ram_cen, ram_gwen, ram_wen, ram_a, ram_d);
      else n_pass++;
      model_write(4'd5, 32'h1234_5678, 4'b1111);
      step();
      drive_req(1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101);
      n_chk++;
      if (ram_wen !== 32'hFF00_FF00 || ram_cen !== 1'b0)
         $display("FAIL partial_wen: wen=%h cen=%b, required ff00ff00 0", ram_wen, ram_cen);
      else n_pass++;
      model_write(4'd5, 32'hAABB_CCDD, 4'b0101);
      step();
      drive_req(1'b0, 4'd5, 32'h0, 4'b0000);
      n_chk++;
      if (ram_cen !== 1'b0 || ram_gwen !== 1'b1 || ram_a !== 4'd5)
         $display("FAIL read_pins: cen=%b gwen=%b a=%0d, required 0 1 5", ram_cen, ram_gwen, ram_a);
      else n_pass++;
      step();
      drive_idle();
      n_chk++;
      if (rd_vld !== 1'b1 || rd_data !== 32'h12BB_56DD)
         $display("FAIL merged_read: rd_vld=%b rd_data=%h, required 1 12bb56dd", rd_vld, rd_data);
      else n_pass++;
      last_rd = 32'h12BB_56DD;
      drive_req(1'b1, 4'd6, $urandom, 4'b1111);
      model_write(4'd6, req_wdata, 4'b1111);
      step();
      drive_idle();
      step();
      step();
      n_chk++;
      if (rd_vld !== 1'b0 || rd_data !== last_rd)
         $display("FAIL read_hold: rd_vld=%b rd_data=%h, required 0 %h", rd_vld, rd_data, last_rd);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b1, AW'(i + 1), vals[i], 4'hF);
         model_write(AW'(i + 1), vals[i], 4'hF);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b0, AW'(i + 1), 32'h0, 4'h0);
         step();
         n_chk++;
         if (rd_vld !== 1'b1 || rd_data !== ref_mem[i + 1] || req_rdy !== 1'b1)
            $display("FAIL b2b_read%0d: rd_vld=%b rd_data=%h rdy=%b, required 1 %h 1",
                     i, rd_vld, rd_data, req_rdy, ref_mem[i + 1]);
         else n_pass++;
      end
      drive_idle();
      last_rd = ref_mem[3];
      step();
      n_chk++;
      if (rd_vld !== 1'b0 || rd_data !== last_rd)
         $display("FAIL b2b_tail: rd_vld=%b rd_data=%h, required 0 %h", rd_vld, rd_data, last_rd);
      else n_pass++;
   endtask

   task automatic test_init_req();
      logic [DW-1:0] old;
      old = ref_mem[2];
      init_req = 1'b1;
      drive_req(1'b0, 4'd2, 32'h0, 4'h0);
      n_chk++;
      if (req_rdy !== 1'b1 || ram_cen !== 1'b0 || ram_a !== 4'd2)
         $display("FAIL initreq_accept: rdy=%b cen=%b a=%0d, required 1 0 2", req_rdy, ram_cen, ram_a);
      else n_pass++;
      step();
      drive_idle();
      n_chk++;
      if (rd_vld !== 1'b1 || rd_data !== old)
         $display("FAIL initreq_rd: rd_vld=%b rd_data=%h, required 1 %h", rd_vld, rd_data, old);
      else n_pass++;
      last_rd = old;
      for (int k = 0; k < DEPTH; k++) begin
         n_chk++;
         if (req_rdy !== 1'b0 || init_done !== 1'b0 || ram_cen !== 1'b0 || ram_a !== k[AW-1:0])
            $display("FAIL resweep_cycle%0d: rdy=%b done=%b cen=%b a=%0d, required 0 0 0 %0d",
                     k, req_rdy, init_done, ram_cen, ram_a, k);
         else n_pass++;
         init_req = (k >= 3 && k < 8);
         step();
      end
      model_sweep();
      n_chk++;
      if (req_rdy !== 1'b1 || rd_data !== last_rd)
         $display("FAIL resweep_end: rdy=%b rd_data=%h, required 1 %h", req_rdy, rd_data, last_rd);
      else n_pass++;
      drive_req(1'b0, 4'd2, 32'h0, 4'h0);
      step();
      drive_idle();
      n_chk++;
      if (rd_vld !== 1'b1 || rd_data !== ref_mem[2])
         $display("FAIL resweep_read: rd_vld=%b rd_data=%h, required 1 %h", rd_vld, rd_data, ref_mem[2]);
      else n_pass++;
      last_rd = ref_mem[2];
   endtask

   task automatic test_reset_mid_sweep();
      drive_req(1'b1, 4'd9, 32'hCAFE_F00D, 4'hF);
      model_write(4'd9, 32'hCAFE_F00D, 4'hF);
      step();
      drive_req(1'b0, 4'd9, 32'h0, 4'h0);
      step();
      drive_idle();
      n_chk++;
      if (rd_vld !== 1'b1 || rd_data !== ref_mem[9])
         $display("FAIL pre_rst_read: rd_vld=%b rd_data=%h, required 1 %h", rd_vld, rd_data, ref_mem[9]);
      else n_pass++;
      init_req = 1'b1;
      #1;
      step();
      init_req = 1'b0;
      repeat (7) step();
      n_chk++;
      if (ram_a !== 4'd7 || ram_cen !== 1'b0)
         $display("FAIL mid_sweep_addr: a=%0d cen=%b, required 7 0", ram_a, ram_cen);
      else n_pass++;
      cpurst_b = 1'b0;
      #1;
      n_chk++;
      if (req_rdy !== 1'b0 || rd_vld !== 1'b0 || rd_data !== 32'h0 || ram_cen !== 1'b1 ||
          ram_gwen !== 1'b1 || ram_wen !== 32'hFFFF_FFFF)
         $display("FAIL mid_rst_vals: rdy=%b rd_vld=%b rd_data=%h cen=%b gwen=%b wen=%h, required 0 0 0 1 1 ffffffff",
                  req_rdy, rd_vld, rd_data, ram_cen, ram_gwen, ram_wen);
      else n_pass++;
      step();
      cpurst_b = 1'b1;
      #1;
      for (int k = 0; k < DEPTH; k++) begin
         n_chk++;
         if (ram_cen !== 1'b0 || ram_gwen !== 1'b0 || ram_a !== k[AW-1:0] || req_rdy !== 1'b0)
            $display("FAIL restart_cycle%0d: cen=%b gwen=%b a=%0d rdy=%b, required 0 0 %0d 0",
                     k, ram_cen, ram_gwen, ram_a, req_rdy, k);
         else n_pass++;
         step();
      end
      n_chk++;
      if (req_rdy !== 1'b1 || init_done !== 1'b1)
         $display("FAIL restart_end: rdy=%b done=%b, required 1 1", req_rdy, init_done);
      else n_pass++;
      model_sweep();
      last_rd = 32'h0;
   endtask

   task automatic test_zero_strobe();
      drive_req(1'b1, 4'd4, 32'hDEAD_BEEF, 4'h0);
      n_chk++;
      if (ram_cen !== 1'b1 || req_rdy !== 1'b1)
         $display("FAIL zero_bwe: cen=%b rdy=%b, required 1 1", ram_cen, req_rdy);
      else n_pass++;
      model_write(4'd4, 32'hDEAD_BEEF, 4'h0);
      step();
      drive_req(1'b0, 4'd4, 32'h0, 4'h0);
      step();
      drive_idle();
      n_chk++;
      if (rd_vld !== 1'b1 || rd_data !== ref_mem[4])
         $display("FAIL zero_bwe_read: rd_vld=%b rd_data=%h, required 1 %h", rd_vld, rd_data, ref_mem[4]);
      else n_pass++;
      last_rd = ref_mem[4];
      step();
   endtask

   task automatic test_random();
      logic          exp_vld;
      logic [DW-1:0] exp_val;
      logic          vld;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [3:0]    bwe;
      exp_vld = 1'b0;
      exp_val = '0;
      for (int i = 0; i < 400; i++) begin
         n_chk++;
         if (rd_vld !== exp_vld || rd_data !== (exp_vld ? exp_val : last_rd) || req_rdy !== 1'b1)
            $display("FAIL rand%0d: rd_vld=%b rd_data=%h rdy=%b, required %b %h 1",
                     i, rd_vld, rd_data, req_rdy, exp_vld, exp_vld ? exp_val : last_rd);
         else n_pass++;
         if (exp_vld) last_rd = exp_val;
         vld  = ($urandom_range(0, 3) != 0);
         wr   = 1'($urandom_range(0, 1));
         addr = AW'($urandom_range(0, DEPTH - 1));
         wd   = $urandom;
         bwe  = 4'($urandom_range(0, 15));
         if (vld) drive_req(wr, addr, wd, bwe);
         else     drive_idle();
         exp_vld = vld & ~wr;
         if (exp_vld) exp_val = ref_mem[addr];
         if (vld && wr) model_write(addr, wd, bwe);
         step();
      end
      drive_idle();
      n_chk++;
      if (rd_vld !== exp_vld || rd_data !== (exp_vld ? exp_val : last_rd))
         $display("FAIL rand_tail: rd_vld=%b rd_data=%h, required %b %h",
                  rd_vld, rd_data, exp_vld, exp_vld ? exp_val : last_rd);
      else n_pass++;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      last_rd = '0;
      test_reset();
      test_byte_strobe();
      test_back_to_back();
      test_init_req();
      test_reset_mid_sweep();
      test_zero_strobe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pa_spsram_ctrl.md
Name: pa_spsram_ctrl

Overview:
- Parametrised controller placed between an LSU/TCM requester and a single-port SRAM macro with active-low CEN/GWEN/bit-WEN.
- Accepts read/write requests over a valid/ready handshake and converts byte strobes to macro bit write-enables.
- Returns read data with a valid pulse and holds that data afterwards.
- Runs a hardware initialisation sweep after reset or on request, writing INIT_VAL to every word.

Parameters:
- ADDR_WIDTH, 12, word-address width; DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- INIT_EN, 1, 1 = run the sweep after reset; 0 = enter IDLE directly after reset.
- INIT_VAL, 0, DATA_WIDTH-bit value written by the sweep.

Ports:
- forever_cpuclk, in, 1: clock.
- cpurst_b, in, 1: asynchronous active-low reset.
- req_vld, in, 1: request valid.
- req_rdy, out, 1: controller ready; equals (state==IDLE).
- req_wr, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_WIDTH: word address.
- req_wdata, in, DATA_WIDTH: write data.
- req_bwe, in, DATA_WIDTH/8: byte write strobes, active-high.
- init_req, in, 1: start a re-initialisation sweep (sampled in IDLE only).
- init_done, out, 1: high in IDLE.
- rd_vld, out, 1: one-cycle read-data-valid pulse.
- rd_data, out, DATA_WIDTH: read data.
- ram_a, out, ADDR_WIDTH: macro address.
- ram_cen, out, 1: macro chip enable, active-low.
- ram_gwen, out, 1: macro global write enable, active-low.
- ram_wen, out, DATA_WIDTH: macro bit write enables, active-low.
- ram_d, out, DATA_WIDTH: macro write data.
- ram_q, in, DATA_WIDTH: macro read data, valid one cycle after a read access.

Behaviour:
- Reset values:
  - state = INIT if INIT_EN, else IDLE; init counter = 0.
  - rd_vld = 0; rd_data hold register = 0.
  - ram_cen = 1, ram_gwen = 1, ram_wen = all-1.
- States are INIT and IDLE.
- INIT:
  - Each cycle: ram_cen=0, ram_gwen=0, ram_wen=all-0, ram_a=counter, ram_d=INIT_VAL; counter increments.
  - After the write to DEPTH-1, the next state is IDLE and the counter clears to 0.
  - The sweep takes exactly DEPTH cycles. req_rdy=0 and init_done=0 throughout.
  - init_req is ignored in INIT.
- IDLE:
  - A request is accepted when req_vld & req_rdy; macro signals are driven combinationally in the same cycle.
  - No request: ram_cen=1.
  - Read: ram_cen=0, ram_gwen=1, ram_a=req_addr. rd_vld=1 in the following cycle, with rd_data=ram_q in that cycle.
  - Write: ram_cen=0, ram_gwen=0, ram_a=req_addr, ram_d=req_wdata, ram_wen[8i+7:8i] = {8{~req_bwe[i]}}. No response.
  - Write with req_bwe all-0: accepted, ram_cen stays 1, no macro access.
  - Back-to-back requests are accepted every cycle. Read-after-write to the same address returns the new data, because the macro access is sequential.
- rd_data hold:
  - In the rd_vld cycle, ram_q is captured into the hold register.
  - In all other cycles rd_data = hold register. rd_data is stable across later writes, idle cycles and sweeps until the next rd_vld.
- init_req in IDLE:
  - Next state is INIT.
  - A request presented in the same cycle is still accepted; the sweep starts the next cycle.
  - rd_vld for a read accepted in that cycle still fires during the first INIT cycle.
- Reset mid-sweep: the counter returns to 0, and the sweep restarts from address 0 after deassertion (INIT_EN=1).
- Only one macro access per cycle; INIT and request accesses never overlap.

Test Plan:
- Reset, INIT_EN=1, ADDR_WIDTH=4:
  - Exactly 16 write cycles, addresses 0..15, with ram_d=0.
  - req_rdy rises in cycle 17; init_done=1.
- Write 0x12345678 to addr 5 with req_bwe=4'b1111, then write 0xAABBCCDD to addr 5 with req_bwe=4'b0101, then read addr 5:
  - Second write drives ram_wen=0xFF00FF00.
  - rd_vld the cycle after the read acceptance, with rd_data=0x12BB56DD; rd_data still 0x12BB56DD three idle cycles later.
- Back-to-back reads of addr 1, 2, 3 in consecutive cycles (memory preloaded with 0x11/0x22/0x33):
  - Three consecutive rd_vld pulses with rd_data 0x11, 0x22, 0x33.
- init_req and a read of addr 2 in the same IDLE cycle:
  - Read accepted; rd_vld=1 with the old data in the first INIT cycle.
  - req_rdy=0 for 16 cycles; a subsequent read of addr 2 returns 0.
- Assert cpurst_b low at sweep address 7:
  - Outputs return to their reset values immediately.
  - After release, the sweep restarts at address 0 and runs 16 cycles.
- Write with req_bwe=0 -> ram_cen stays 1 that cycle; req_rdy stays 1.
